cpu_trace_checker: RTL and testbench
====================================

CPU_TRACE_CHECKER -- requirements
Module: cpu_trace_checker

Interface
REQ-001 Parameter DATA_W, default 16, observed register width.
REQ-002 Parameter PC_W, default 5, program counter width.
REQ-003 Parameter NUM_CHECKS, default 16, expectation table depth (>=2); IDX_W = clog2(NUM_CHECKS).
REQ-004 Parameter TIMEOUT, default 255, maximum RUN cycles allowed between checkpoints (>=1).
REQ-005 clock  in  1  sole clock, all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  begin a checking run (level-sampled).
REQ-008 pc_in  in  PC_W  core PC (PC_out of cpu_core).
REQ-009 obs_data  in  DATA_W  observed register value (r7_data of cpu_core).
REQ-010 cfg_we  in  1  write one table entry.
REQ-011 cfg_addr  in  IDX_W  entry index.
REQ-012 cfg_valid  in  1  entry valid bit.
REQ-013 cfg_pc  in  PC_W  checkpoint PC.
REQ-014 cfg_expected  in  DATA_W  expected value.
REQ-015 cfg_mask  in  DATA_W  compare mask; 1 = bit compared.
REQ-016 busy  out  1  state is RUN.
REQ-017 done  out  1  state is PASS or FAIL.
REQ-018 pass  out  1  state is PASS.
REQ-019 timeout  out  1  last FAIL caused by timeout.
REQ-020 fail_index  out  IDX_W  entry index at failure.
REQ-021 fail_observed  out  DATA_W  obs_data sampled at failure.
REQ-022 checks_passed  out  clog2(NUM_CHECKS+1)  checkpoints passed in current/last run.

Function
REQ-023 Table SHALL hold NUM_CHECKS entries {valid, pc, expected, mask}; cfg_we with state != RUN SHALL write entry cfg_addr at that edge; cfg_we in RUN SHALL be ignored.
REQ-024 Table contents SHALL persist across runs; only reset clears valid bits.
REQ-025 States SHALL be IDLE, RUN, PASS, FAIL.
REQ-026 start=1 in IDLE, PASS or FAIL SHALL enter RUN next cycle, clearing idx, checks_passed, timeout counter, timeout, fail_index, fail_observed; start in RUN SHALL be ignored.
REQ-027 pc_prev SHALL register pc_in every cycle in every state; pc_edge = (pc_in != pc_prev).
REQ-028 In RUN, if entry[idx].valid=0, SHALL enter PASS next cycle (end of list; zero valid entries at idx 0 passes).
REQ-029 In RUN, a check SHALL fire on a cycle with pc_edge=1 and pc_in == entry[idx].pc; PC repeats without an edge (branch-to-self) SHALL NOT re-fire.
REQ-030 Fired check SHALL pass when (obs_data & mask) == (expected & mask), compared combinationally in the firing cycle.
REQ-031 Pass: checks_passed++, timeout counter cleared, idx++; if idx was NUM_CHECKS-1, enter PASS next cycle.
REQ-032 Mismatch: enter FAIL next cycle, fail_index=idx, fail_observed=obs_data, timeout=0.
REQ-033 Timeout counter SHALL increment each RUN cycle without a passing check; reaching TIMEOUT SHALL enter FAIL with timeout=1, fail_index=idx, fail_observed=obs_data.
REQ-034 Simultaneous check fire and timeout limit: check result SHALL take priority.
REQ-035 Checks against entries other than entry[idx] SHALL NOT occur (strictly ordered).
REQ-036 PASS and FAIL SHALL hold until start or reset; outputs stable while held.
REQ-037 Latency: start edge N -> busy=1 at N+1; final check at edge M -> done=1 at M+1.

Reset
REQ-038 reset=0 SHALL immediately force IDLE, all outputs 0, idx=0, counters 0, pc_prev=0, all valid bits 0, regardless of clock or run in progress.
REQ-039 Release of reset SHALL take effect synchronously on the first rising edge with reset=1; no run starts without a new start.

Verification
REQ-040 Load entries 0-2 {pc 7,11,15; expected 6,1,15; mask 0xFFFF}, entry 3 invalid; drive matching sequence -> pass=1, checks_passed=3, done one cycle after PC=15 edge.
REQ-041 Same table, obs_data=9 at PC 11 -> FAIL, fail_index=1, fail_observed=9, timeout=0, checks_passed=1.
REQ-042 TIMEOUT=10, pc_in held at 3 after start -> FAIL at 10th RUN cycle, timeout=1, fail_index=0.
REQ-043 Mask 0x00FF, expected 0x1234, obs_data 0xAB34 -> check passes; pc_in repeats at 7 with no edge -> no second check.
REQ-044 Assert reset mid-RUN -> busy=0 immediately, valid bits cleared; subsequent start with empty table -> PASS, checks_passed=0.
REQ-045 cfg_we in RUN altering entry idx -> ignored, original expected value still applied.

Source files
------------

// File: rtl/cpu_trace_checker.sv
`timescale 1ns/1ps
// Ordered checkpoint checker: at each new PC matching the current table entry, compares obs_data under a mask.
// Latency: busy one cycle after start, done one cycle after the deciding check; purely observes, no backpressure.
module cpu_trace_checker #(
  parameter int DATA_W     = 16,
  parameter int PC_W       = 5,
  parameter int NUM_CHECKS = 16,
  parameter int TIMEOUT    = 255,
  localparam int IDX_W = $clog2(NUM_CHECKS),
  localparam int CP_W  = $clog2(NUM_CHECKS + 1),
  localparam int TO_W  = $clog2(TIMEOUT + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [DATA_W-1:0] obs_data,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_addr,
  input  logic              cfg_valid,
  input  logic [PC_W-1:0]   cfg_pc,
  input  logic [DATA_W-1:0] cfg_expected,
  input  logic [DATA_W-1:0] cfg_mask,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [IDX_W-1:0]  fail_index,
  output logic [DATA_W-1:0] fail_observed,
  output logic [CP_W-1:0]   checks_passed
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_PASS = 2'd2;
  localparam logic [1:0] ST_FAIL = 2'd3;

  logic [1:0]        state;
  logic [IDX_W-1:0]  idx;
  logic [TO_W-1:0]   tmo_cnt;
  logic [PC_W-1:0]   pc_prev;

  logic              tbl_valid    [NUM_CHECKS];
  logic [PC_W-1:0]   tbl_pc       [NUM_CHECKS];
  logic [DATA_W-1:0] tbl_expected [NUM_CHECKS];
  logic [DATA_W-1:0] tbl_mask     [NUM_CHECKS];

  logic              cur_valid;
  logic              pc_edge;
  logic              fire;
  logic              match;
  logic              last_idx;
  logic [IDX_W-1:0]  nxt_idx;
  logic              nxt_valid;
  logic              tmo_hit;

  assign cur_valid = tbl_valid[idx];
  assign pc_edge   = (pc_in != pc_prev);
  assign fire      = pc_edge && (pc_in == tbl_pc[idx]);
  assign match     = ((obs_data ^ tbl_expected[idx]) & tbl_mask[idx]) == '0;
  assign last_idx  = (idx == IDX_W'(NUM_CHECKS - 1));
  assign nxt_idx   = idx + IDX_W'(1);
  // Look one entry ahead so the final passing check completes the run without an extra cycle.
  assign nxt_valid = last_idx ? 1'b0 : tbl_valid[nxt_idx];
  assign tmo_hit   = (tmo_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      idx           <= '0;
      tmo_cnt       <= '0;
      pc_prev       <= '0;
      timeout       <= 1'b0;
      fail_index    <= '0;
      fail_observed <= '0;
      checks_passed <= '0;
    end else begin
      pc_prev <= pc_in;
      case (state)
        ST_RUN: begin
          if (!cur_valid) begin
            state <= ST_PASS;
          end else if (fire) begin
            if (match) begin
              checks_passed <= checks_passed + CP_W'(1);
              tmo_cnt       <= '0;
              if (!last_idx) idx <= nxt_idx;
              if (!nxt_valid) state <= ST_PASS;
            end else begin
              state         <= ST_FAIL;
              timeout       <= 1'b0;
              fail_index    <= idx;
              fail_observed <= obs_data;
            end
          end else if (tmo_hit) begin
            state         <= ST_FAIL;
            timeout       <= 1'b1;
            fail_index    <= idx;
            fail_observed <= obs_data;
          end else begin
            tmo_cnt <= tmo_cnt + TO_W'(1);
          end
        end
        default: begin
          if (start) begin
            state         <= ST_RUN;
            idx           <= '0;
            tmo_cnt       <= '0;
            timeout       <= 1'b0;
            fail_index    <= '0;
            fail_observed <= '0;
            checks_passed <= '0;
          end
        end
      endcase
    end
  end

  // Table writes are locked out while a run is consuming the entries.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CHECKS; i++) tbl_valid[i] <= 1'b0;
    end else if (cfg_we && state != ST_RUN) begin
      tbl_valid[cfg_addr] <= cfg_valid;
    end
  end

  always_ff @(posedge clock) begin
    if (cfg_we && state != ST_RUN) begin
      tbl_pc[cfg_addr]       <= cfg_pc;
      tbl_expected[cfg_addr] <= cfg_expected;
      tbl_mask[cfg_addr]     <= cfg_mask;
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_PASS) || (state == ST_FAIL);
  assign pass = (state == ST_PASS);

endmodule

// File: tb/tb_cpu_trace_checker.sv
`timescale 1ns/1ps
// Bench for cpu_trace_checker: directed scenarios plus randomized tables/PC traces scored by a trace-walking model.
module tb_cpu_trace_checker;
  localparam int DW = 16, PW = 5, NC = 4, IW = 2, CW = 3, TO = 10, MAXL = 48;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [PW-1:0] pc_in = '0;
  logic [DW-1:0] obs_data = '0;
  logic          cfg_we = 1'b0;
  logic [IW-1:0] cfg_addr = '0;
  logic          cfg_valid = 1'b0;
  logic [PW-1:0] cfg_pc = '0;
  logic [DW-1:0] cfg_expected = '0;
  logic [DW-1:0] cfg_mask = '0;
  logic          busy, done, pass, timeout;
  logic [IW-1:0] fail_index;
  logic [DW-1:0] fail_observed;
  logic [CW-1:0] checks_passed;

  cpu_trace_checker #(.DATA_W(DW), .PC_W(PW), .NUM_CHECKS(NC), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .start(start), .pc_in(pc_in), .obs_data(obs_data),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid), .cfg_pc(cfg_pc),
    .cfg_expected(cfg_expected), .cfg_mask(cfg_mask), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .fail_index(fail_index), .fail_observed(fail_observed),
    .checks_passed(checks_passed)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Mirror of what the table should hold, and the per-RUN-cycle trace to apply.
  logic          t_valid [NC];
  logic [PW-1:0] t_pc    [NC];
  logic [DW-1:0] t_exp   [NC];
  logic [DW-1:0] t_mask  [NC];
  logic [PW-1:0] s_pc    [MAXL];
  logic [DW-1:0] s_obs   [MAXL];
  logic [PW-1:0] s_pc0;

  int            o_k, e_k;
  logic          o_pass, o_tmo, o_busy1, o_stable, e_pass, e_tmo;
  logic [IW-1:0] o_fidx, e_fidx;
  logic [DW-1:0] o_fobs, e_fobs;
  logic [CW-1:0] o_cp, e_cp;

  task automatic write_entry(input int a, input logic v, input logic [PW-1:0] p,
                             input logic [DW-1:0] e, input logic [DW-1:0] m);
    @(negedge clock);
    cfg_we = 1'b1; cfg_addr = a[IW-1:0]; cfg_valid = v; cfg_pc = p; cfg_expected = e; cfg_mask = m;
    @(posedge clock);
    #1 cfg_we = 1'b0;
    t_valid[a] = v; t_pc[a] = p; t_exp[a] = e; t_mask[a] = m;
  endtask

  task automatic hold_fill(input int from);
    for (int k = from; k < MAXL; k++) begin
      s_pc[k]  = (k == 0) ? s_pc0 : s_pc[k-1];
      s_obs[k] = (k == 0) ? 16'h0 : s_obs[k-1];
    end
  endtask

  // Drives start, then one trace entry per RUN cycle; o_k is the trace cycle whose edge raised done.
  task automatic run_seq();
    logic [40:0] snap;
    o_k = -1;
    @(negedge clock);
    start = 1'b1; pc_in = s_pc0; obs_data = DW'($urandom);
    @(negedge clock);
    start = 1'b0;
    o_busy1 = busy;
    for (int k = 0; k < MAXL; k++) begin
      pc_in = s_pc[k]; obs_data = s_obs[k];
      @(negedge clock);
      if (done) begin o_k = k; break; end
    end
    o_pass = pass; o_tmo = timeout; o_fidx = fail_index; o_fobs = fail_observed; o_cp = checks_passed;
    snap = {busy, done, pass, timeout, fail_index, fail_observed, checks_passed, 16'h0};
    o_stable = 1'b1;
    repeat (3) begin
      pc_in = PW'($urandom); obs_data = DW'($urandom);
      @(negedge clock);
      if ({busy, done, pass, timeout, fail_index, fail_observed, checks_passed, 16'h0} !== snap)
        o_stable = 1'b0;
    end
  endtask

  // Walks the trace against the mirrored table in checkpoint order.
  task automatic model_run();
    int idx, cp, since;
    logic [PW-1:0] prev;
    idx = 0; cp = 0; since = 0; prev = s_pc0;
    e_k = -1; e_pass = 0; e_tmo = 0; e_fidx = '0; e_fobs = '0;
    for (int k = 0; k < MAXL; k++) begin
      if (!t_valid[idx]) begin e_pass = 1; e_k = k; break; end
      if (s_pc[k] != prev && s_pc[k] == t_pc[idx]) begin
        if ((s_obs[k] & t_mask[idx]) == (t_exp[idx] & t_mask[idx])) begin
          cp++; since = 0; idx++;
          if (idx == NC) begin e_pass = 1; e_k = k; break; end
          if (!t_valid[idx]) begin e_pass = 1; e_k = k; break; end
        end else begin
          e_fidx = idx[IW-1:0]; e_fobs = s_obs[k]; e_k = k; break;
        end
      end else begin
        since++;
        if (since == TO) begin e_tmo = 1; e_fidx = idx[IW-1:0]; e_fobs = s_obs[k]; e_k = k; break; end
      end
      prev = s_pc[k];
    end
    e_cp = cp[CW-1:0];
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    n_tests++;
    if ({busy, done, pass, timeout, fail_index, fail_observed, checks_passed} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %0h expected 0",
        {busy, done, pass, timeout, fail_index, fail_observed, checks_passed});
    end
    reset = 1'b1;
    for (int i = 0; i < NC; i++) t_valid[i] = 1'b0;
    repeat (3) @(negedge clock);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_autostart: busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic load_basic_table();
    write_entry(0, 1, 5'd7, 16'd6, 16'hFFFF);
    write_entry(1, 1, 5'd11, 16'd1, 16'hFFFF);
    write_entry(2, 1, 5'd15, 16'd15, 16'hFFFF);
    write_entry(3, 0, 5'd0, 16'd0, 16'hFFFF);
  endtask

  task automatic test_pass_sequence();
    load_basic_table();
    s_pc0 = 5'd0;
    s_pc[0] = 5'd1;  s_obs[0] = 16'd0;
    s_pc[1] = 5'd7;  s_obs[1] = 16'd6;
    s_pc[2] = 5'd3;  s_obs[2] = 16'd0;
    s_pc[3] = 5'd11; s_obs[3] = 16'd1;
    s_pc[4] = 5'd2;  s_obs[4] = 16'd0;
    s_pc[5] = 5'd15; s_obs[5] = 16'd15;
    hold_fill(6);
    run_seq();
    n_tests++;
    if (o_busy1 !== 1'b1) begin n_fail++; $display("FAIL pass_busy_latency: got %b expected 1", o_busy1); end
    n_tests++;
    if (o_k != 5) begin n_fail++; $display("FAIL pass_done_cycle: got %0d expected 5", o_k); end
    n_tests++;
    if (o_pass !== 1'b1 || o_cp !== 3'd3 || o_tmo !== 1'b0) begin
      n_fail++; $display("FAIL pass_result: pass=%b cp=%0d tmo=%b expected 1 3 0", o_pass, o_cp, o_tmo);
    end
    n_tests++;
    if (o_stable !== 1'b1) begin n_fail++; $display("FAIL pass_hold: outputs changed while held, expected stable"); end
  endtask

  task automatic test_mismatch();
    s_pc0 = 5'd0;
    s_pc[0] = 5'd7;  s_obs[0] = 16'd6;
    s_pc[1] = 5'd11; s_obs[1] = 16'd9;
    hold_fill(2);
    run_seq();
    n_tests++;
    if (o_k != 1) begin n_fail++; $display("FAIL mismatch_done_cycle: got %0d expected 1", o_k); end
    n_tests++;
    if (o_pass !== 1'b0 || o_fidx !== 2'd1 || o_fobs !== 16'd9 || o_tmo !== 1'b0 || o_cp !== 3'd1) begin
      n_fail++; $display("FAIL mismatch_result: pass=%b idx=%0d obs=%0d tmo=%b cp=%0d expected 0 1 9 0 1",
        o_pass, o_fidx, o_fobs, o_tmo, o_cp);
    end
  endtask

  task automatic test_timeout();
    s_pc0 = 5'd3;
    for (int k = 0; k < MAXL; k++) begin s_pc[k] = 5'd3; s_obs[k] = 16'h0100 + 16'(k); end
    run_seq();
    n_tests++;
    if (o_k != 9) begin n_fail++; $display("FAIL timeout_cycle: got %0d expected 9", o_k); end
    n_tests++;
    if (o_tmo !== 1'b1 || o_fidx !== 2'd0 || o_pass !== 1'b0 || o_fobs !== 16'h0109) begin
      n_fail++; $display("FAIL timeout_result: tmo=%b idx=%0d pass=%b obs=%0h expected 1 0 0 109",
        o_tmo, o_fidx, o_pass, o_fobs);
    end
  endtask

  task automatic test_mask_no_refire();
    write_entry(0, 1, 5'd7, 16'h1234, 16'h00FF);
    write_entry(1, 1, 5'd7, 16'h0000, 16'hFFFF);
    write_entry(2, 0, 5'd0, 16'h0000, 16'h0000);
    s_pc0 = 5'd0;
    for (int k = 0; k < 4; k++) begin s_pc[k] = 5'd7; s_obs[k] = 16'hAB34; end
    s_pc[4] = 5'd2; s_obs[4] = 16'h0;
    s_pc[5] = 5'd7; s_obs[5] = 16'h0;
    hold_fill(6);
    run_seq();
    n_tests++;
    if (o_k != 5 || o_pass !== 1'b1 || o_cp !== 3'd2) begin
      n_fail++; $display("FAIL mask_no_refire: k=%0d pass=%b cp=%0d expected 5 1 2", o_k, o_pass, o_cp);
    end
  endtask

  task automatic test_cfg_in_run();
    write_entry(0, 1, 5'd4, 16'h00AA, 16'hFFFF);
    write_entry(1, 0, 5'd0, 16'h0, 16'h0);
    @(negedge clock); start = 1'b1; pc_in = 5'd0;
    @(negedge clock); start = 1'b0;
    cfg_we = 1'b1; cfg_addr = 2'd0; cfg_valid = 1'b1; cfg_pc = 5'd4; cfg_expected = 16'h0055; cfg_mask = 16'hFFFF;
    @(negedge clock); cfg_we = 1'b0; pc_in = 5'd4; obs_data = 16'h00AA;
    @(negedge clock);
    n_tests++;
    if (pass !== 1'b1 || checks_passed !== 3'd1) begin
      n_fail++; $display("FAIL cfg_in_run: pass=%b cp=%0d expected 1 1", pass, checks_passed);
    end
    s_pc0 = 5'd0; s_pc[0] = 5'd4; s_obs[0] = 16'h00AA;
    hold_fill(1);
    run_seq();
    n_tests++;
    if (o_k != 0 || o_pass !== 1'b1) begin
      n_fail++; $display("FAIL cfg_persist: k=%0d pass=%b expected 0 1", o_k, o_pass);
    end
  endtask

  task automatic test_reset_mid_run();
    write_entry(0, 1, 5'd9, 16'h0042, 16'hFFFF);
    @(negedge clock); start = 1'b1; pc_in = 5'd1;
    @(negedge clock); start = 1'b0;
    repeat (2) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b0 || checks_passed !== '0) begin
      n_fail++; $display("FAIL reset_mid_run: busy=%b cp=%0d expected 0 0", busy, checks_passed);
    end
    @(negedge clock); reset = 1'b1;
    for (int i = 0; i < NC; i++) t_valid[i] = 1'b0;
    s_pc0 = 5'd1; s_pc[0] = 5'd9; s_obs[0] = 16'h0042;
    hold_fill(1);
    run_seq();
    n_tests++;
    if (o_k != 0 || o_pass !== 1'b1 || o_cp !== 3'd0) begin
      n_fail++; $display("FAIL empty_after_reset: k=%0d pass=%b cp=%0d expected 0 1 0", o_k, o_pass, o_cp);
    end
  endtask

  // Back-to-back random runs: each new table is written from the PASS/FAIL state of the previous run.
  task automatic test_random();
    int nv, k, gap;
    logic [PW-1:0] p;
    logic [DW-1:0] m;
    for (int it = 0; it < 40; it++) begin
      nv = $urandom_range(0, NC);
      for (int i = 0; i < NC; i++) begin
        case ($urandom_range(0, 2))
          0: m = 16'hFFFF;
          1: m = 16'h00FF;
          default: m = DW'($urandom);
        endcase
        write_entry(i, (i < nv) || (i > nv && $urandom_range(0, 3) == 0), PW'($urandom), DW'($urandom), m);
      end
      s_pc0 = PW'($urandom);
      k = 0;
      for (int c = 0; c < NC; c++) begin
        gap = $urandom_range(0, 10);
        for (int g = 0; g < gap; g++) begin
          p = PW'($urandom);
          if (p == t_pc[c]) p = p + 1'b1;
          s_pc[k] = p; s_obs[k] = DW'($urandom); k++;
        end
        s_pc[k] = t_pc[c];
        s_obs[k] = ($urandom_range(0, 9) < 8) ? ((t_exp[c] & t_mask[c]) | (DW'($urandom) & ~t_mask[c]))
                                              : DW'($urandom);
        k++;
      end
      hold_fill(k);
      model_run();
      run_seq();
      n_tests++;
      if (o_busy1 !== 1'b1) begin n_fail++; $display("FAIL rnd_busy it=%0d: got %b expected 1", it, o_busy1); end
      n_tests++;
      if (o_k != e_k) begin n_fail++; $display("FAIL rnd_done_cycle it=%0d: got %0d expected %0d", it, o_k, e_k); end
      n_tests++;
      if ({o_pass, o_tmo, o_fidx, o_fobs, o_cp} !== {e_pass, e_tmo, e_fidx, e_fobs, e_cp}) begin
        n_fail++;
        $display("FAIL rnd_result it=%0d: got pass=%b tmo=%b idx=%0d obs=%0h cp=%0d expected %b %b %0d %0h %0d",
          it, o_pass, o_tmo, o_fidx, o_fobs, o_cp, e_pass, e_tmo, e_fidx, e_fobs, e_cp);
      end
      n_tests++;
      if (o_stable !== 1'b1) begin n_fail++; $display("FAIL rnd_hold it=%0d: outputs not stable, expected stable", it); end
    end
  endtask

  initial begin
    test_reset();
    test_pass_sequence();
    test_mismatch();
    test_timeout();
    test_mask_no_refire();
    test_cfg_in_run();
    test_reset_mid_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

endmodule
